acorn_phase_ctrl: RTL and testbench
===================================

Name: acorn_phase_ctrl

Overview:
Top-level sequencer for the bit-serial ACORN-128 datapath. It drives one state_update128 step per enabled cycle and generates the per-step control bits (ca, cb, mbit) for every phase: initialization, associated-data absorb, AD padding, encryption, encryption padding and finalization/tag. Data bits enter through a valid/ready stream. Ciphertext and tag bits are qualified strobes, with the XOR against keystream done downstream.

Parameters:
LEN_W, 16, width of ad_len/msg_len in bits (max 2^LEN_W-1 bits each)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
key  in  128  key, bit i = K_i; latched on accepted start
iv  in  128  IV, bit i = IV_i; latched on accepted start
ad_len  in  LEN_W  associated-data length in bits; latched on start
msg_len  in  LEN_W  plaintext length in bits; latched on start
din_valid  in  1  data bit available (AD bit in AD phase, PT bit in ENC phase)
din  in  1  data bit
din_ready  out  1  controller consumes din this cycle if din_valid
step_en  out  1  datapath performs one state update this cycle
ca  out  1  ca control for this step
cb  out  1  cb control for this step
mbit  out  1  message bit for this step
phase  out  3  current phase code (package constant)
ct_valid  out  1  this step's keystream XOR din is a ciphertext bit
tag_valid  out  1  this step's keystream bit is a tag bit
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last finalization step

Behaviour:
- Reset (async, rst_n=0): FSM->IDLE, counters=0, latched key/iv/lengths=0. All outputs 0, including din_ready and done.
- States: IDLE, INIT, AD, AD_PAD, ENC, ENC_PAD, FINAL, DONE. Step counter scnt is 11 bits. Data counter dcnt is LEN_W bits.
- IDLE: start=1 at edge T0 latches inputs, clears counters, ->INIT. First step_en is at cycle T0+1. start is ignored outside IDLE.
- INIT: step_en=1 every cycle for 1792 steps; ca=1, cb=1.
  - mbit = key[i] for i<128; iv[i-128] for 128<=i<256; key[0]^1 for i=256; key[i mod 128] for 257<=i<1792.
  - After step 1791: ->AD if ad_len!=0, else ->AD_PAD.
- AD: din_ready=1; step_en=din_valid; mbit=din; ca=1; cb=1. dcnt increments per consumed bit. Stalls (step_en=0) while din_valid=0. After bit ad_len-1: ->AD_PAD.
- AD_PAD: 256 steps, step_en=1; mbit=1 on step 0, else 0; ca=1 for steps 0..127, 0 for 128..255; cb=1. Then ->ENC if msg_len!=0, else ->ENC_PAD.
- ENC: din_ready=1; step_en=din_valid; mbit=din; ca=1; cb=0; ct_valid=step_en. After bit msg_len-1: ->ENC_PAD.
- ENC_PAD: same as AD_PAD except cb=0. Then ->FINAL.
- FINAL: 768 steps, step_en=1, mbit=0, ca=1, cb=1. tag_valid=1 on steps 640..767; tag bit index = step-640. Then ->DONE.
- DONE: done=1 for one cycle, busy=0, ->IDLE. A start in DONE is ignored.
- din_ready=0 and ct_valid=0 outside AD/ENC. ca/cb/mbit are 0 whenever step_en=0.
- Zero-length run (ad_len=0, msg_len=0) takes 3072 steps; done is high at T0+3073.
- Counters reset to 0 at every phase transition. No wrap within a phase. dcnt compare uses full LEN_W.
- din_valid held high with no stall gives fully continuous steps. A stall inserts bubbles only; no step is lost or repeated.
- rst_n asserted mid-run aborts immediately. The datapath state is then undefined and must be re-initialized by a new start.

Decomposition:
- Package acorn_pkg: INIT_STEPS=1792, PAD_STEPS=256, PAD_CA_STEPS=128, FINAL_STEPS=768, TAG_START=640, KEY_BITS=128, and 3-bit phase encodings: IDLE=0, INIT=1, AD=2, AD_PAD=3, ENC=4, ENC_PAD=5, FINAL=6, DONE=7.
- One sub-module: acorn_init_mbit_sel, a combinational INIT mbit mux from key, iv and scnt.
- FSM, counters and handshake stay in acorn_phase_ctrl.

Test Plan:
- ad_len=0, msg_len=0, key=0, iv=0, start at T0 -> step_en high T0+1..T0+3072 continuous; done pulse at T0+3073; tag_valid high exactly 128 cycles; phase sequence 1,3,5,6,7,0.
- INIT mbit check with key=128'h1, iv=all-ones -> mbit step0=1, steps1..127=0, 128..255=1, step256=0 (key[0]^1), step257=0, step384=1.
- ad_len=8, msg_len=4, din_valid toggling 1/0 each cycle -> exactly 8 AD steps with ca=1,cb=1 and 4 ENC steps with cb=0 and ct_valid=step_en; no steps during din_valid=0 bubbles.
- AD_PAD/ENC_PAD shape -> mbit=1 only on pad step 0; ca drops to 0 at pad step 128; cb=1 in AD_PAD, 0 in ENC_PAD.
- start re-pulsed during ENC and during DONE -> ignored, latched lengths unchanged, single done pulse.
- rst_n low at INIT step 500 -> all outputs 0 asynchronously, busy=0; a subsequent start runs the full 3072-step sequence from INIT step 0.

Source files
------------

// File: rtl/acorn_pkg.sv
// Shared constants and phase encoding for the ACORN-128 bit-serial phase sequencer.
package acorn_pkg;

  localparam int unsigned INIT_STEPS   = 1792;
  localparam int unsigned PAD_STEPS    = 256;
  localparam int unsigned PAD_CA_STEPS = 128;
  localparam int unsigned FINAL_STEPS  = 768;
  localparam int unsigned TAG_START    = 640;
  localparam int unsigned KEY_BITS     = 128;
  localparam int unsigned SCNT_W       = 11;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_INIT    = 3'd1,
    PH_AD      = 3'd2,
    PH_AD_PAD  = 3'd3,
    PH_ENC     = 3'd4,
    PH_ENC_PAD = 3'd5,
    PH_FINAL   = 3'd6,
    PH_DONE    = 3'd7
  } phase_e;

endpackage

// File: rtl/acorn_phase_ctrl_if.sv
// Start/config inputs, data stream handshake and per-step control outputs of the sequencer.
interface acorn_phase_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [127:0]     key;
  logic [127:0]     iv;
  logic [LEN_W-1:0] ad_len;
  logic [LEN_W-1:0] msg_len;
  logic             din_valid;
  logic             din;
  logic             din_ready;
  logic             step_en;
  logic             ca;
  logic             cb;
  logic             mbit;
  logic [2:0]       phase;
  logic             ct_valid;
  logic             tag_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, key, iv, ad_len, msg_len, din_valid, din,
    input  din_ready, step_en, ca, cb, mbit, phase, ct_valid, tag_valid, busy, done
  );

  modport slave (
    input  start, key, iv, ad_len, msg_len, din_valid, din,
    output din_ready, step_en, ca, cb, mbit, phase, ct_valid, tag_valid, busy, done
  );
endinterface

// File: rtl/acorn_init_mbit_sel.sv
// INIT-phase message bit: key, then IV, then key[0] inverted once, then key repeated.
module acorn_init_mbit_sel
  import acorn_pkg::*;
(
  input  logic [KEY_BITS-1:0] key,
  input  logic [KEY_BITS-1:0] iv,
  input  logic [SCNT_W-1:0]   scnt,
  output logic                mbit
);

  localparam logic [SCNT_W-1:0] IV_FIRST = SCNT_W'(KEY_BITS);
  localparam logic [SCNT_W-1:0] IV_END   = SCNT_W'(2 * KEY_BITS);

  logic [$clog2(KEY_BITS)-1:0] idx_s;
  assign idx_s = scnt[$clog2(KEY_BITS)-1:0];

  // Select the INIT message bit for the current step index.
  always_comb begin
    if (scnt < IV_FIRST) begin
      mbit = key[idx_s];
    end else if (scnt < IV_END) begin
      mbit = iv[idx_s];
    end else if (scnt == IV_END) begin
      mbit = ~key[0];
    end else begin
      mbit = key[idx_s];
    end
  end

endmodule

// File: rtl/acorn_phase_ctrl.sv
// ACORN-128 phase sequencer: walks INIT/AD/pad/ENC/pad/FINAL and emits one step's control bits per cycle.
module acorn_phase_ctrl
  import acorn_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  acorn_phase_ctrl_if.slave  bus
);

  localparam logic [SCNT_W-1:0] SCNT_ZERO  = {SCNT_W{1'b0}};
  localparam logic [SCNT_W-1:0] SCNT_ONE   = SCNT_W'(1);
  localparam logic [SCNT_W-1:0] INIT_LAST  = SCNT_W'(INIT_STEPS - 1);
  localparam logic [SCNT_W-1:0] PAD_LAST   = SCNT_W'(PAD_STEPS - 1);
  localparam logic [SCNT_W-1:0] PAD_CA_END = SCNT_W'(PAD_CA_STEPS);
  localparam logic [SCNT_W-1:0] FINAL_LAST = SCNT_W'(FINAL_STEPS - 1);
  localparam logic [SCNT_W-1:0] TAG_FIRST  = SCNT_W'(TAG_START);
  localparam logic [LEN_W-1:0]  LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  phase_e              state_q, state_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [LEN_W-1:0]    dcnt_q, dcnt_d;
  logic [LEN_W-1:0]    ad_len_q, ad_len_d;
  logic [LEN_W-1:0]    msg_len_q, msg_len_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [KEY_BITS-1:0] iv_q, iv_d;

  logic init_mbit_s;
  logic step_en_s, ca_s, cb_s, mbit_s, din_ready_s, ct_valid_s, tag_valid_s, busy_s, done_s;

  acorn_init_mbit_sel u_init_mbit_sel (
    .key  (key_q),
    .iv   (iv_q),
    .scnt (scnt_q),
    .mbit (init_mbit_s)
  );

  // Next-state, counter and per-step control decode.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    dcnt_d      = dcnt_q;
    ad_len_d    = ad_len_q;
    msg_len_d   = msg_len_q;
    key_d       = key_q;
    iv_d        = iv_q;
    step_en_s   = 1'b0;
    ca_s        = 1'b0;
    cb_s        = 1'b0;
    mbit_s      = 1'b0;
    din_ready_s = 1'b0;
    ct_valid_s  = 1'b0;
    tag_valid_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;

    case (state_q)
      PH_IDLE: begin
        if (bus.start) begin
          state_d   = PH_INIT;
          key_d     = bus.key;
          iv_d      = bus.iv;
          ad_len_d  = bus.ad_len;
          msg_len_d = bus.msg_len;
          scnt_d    = SCNT_ZERO;
          dcnt_d    = LEN_ZERO;
        end else begin
          state_d = PH_IDLE;
        end
      end
      PH_INIT: begin
        busy_s    = 1'b1;
        step_en_s = 1'b1;
        ca_s      = 1'b1;
        cb_s      = 1'b1;
        mbit_s    = init_mbit_s;
        if (scnt_q == INIT_LAST) begin
          scnt_d  = SCNT_ZERO;
          state_d = (ad_len_q != LEN_ZERO) ? PH_AD : PH_AD_PAD;
        end else begin
          scnt_d = scnt_q + SCNT_ONE;
        end
      end
      PH_AD: begin
        busy_s      = 1'b1;
        din_ready_s = 1'b1;
        if (bus.din_valid) begin
          step_en_s = 1'b1;
          ca_s      = 1'b1;
          cb_s      = 1'b1;
          mbit_s    = bus.din;
          if (dcnt_q == ad_len_q - LEN_ONE) begin
            dcnt_d  = LEN_ZERO;
            state_d = PH_AD_PAD;
          end else begin
            dcnt_d = dcnt_q + LEN_ONE;
          end
        end else begin
          step_en_s = 1'b0;
        end
      end
      PH_AD_PAD, PH_ENC_PAD: begin
        busy_s    = 1'b1;
        step_en_s = 1'b1;
        mbit_s    = (scnt_q == SCNT_ZERO);
        ca_s      = (scnt_q < PAD_CA_END);
        cb_s      = (state_q == PH_AD_PAD);
        if (scnt_q == PAD_LAST) begin
          scnt_d = SCNT_ZERO;
          if (state_q == PH_ENC_PAD) begin
            state_d = PH_FINAL;
          end else begin
            state_d = (msg_len_q != LEN_ZERO) ? PH_ENC : PH_ENC_PAD;
          end
        end else begin
          scnt_d = scnt_q + SCNT_ONE;
        end
      end
      PH_ENC: begin
        busy_s      = 1'b1;
        din_ready_s = 1'b1;
        if (bus.din_valid) begin
          step_en_s  = 1'b1;
          ca_s       = 1'b1;
          cb_s       = 1'b0;
          mbit_s     = bus.din;
          ct_valid_s = 1'b1;
          if (dcnt_q == msg_len_q - LEN_ONE) begin
            dcnt_d  = LEN_ZERO;
            state_d = PH_ENC_PAD;
          end else begin
            dcnt_d = dcnt_q + LEN_ONE;
          end
        end else begin
          step_en_s = 1'b0;
        end
      end
      PH_FINAL: begin
        busy_s      = 1'b1;
        step_en_s   = 1'b1;
        ca_s        = 1'b1;
        cb_s        = 1'b1;
        tag_valid_s = (scnt_q >= TAG_FIRST);
        if (scnt_q == FINAL_LAST) begin
          scnt_d  = SCNT_ZERO;
          state_d = PH_DONE;
        end else begin
          scnt_d = scnt_q + SCNT_ONE;
        end
      end
      PH_DONE: begin
        done_s  = 1'b1;
        state_d = PH_IDLE;
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase
  end

  // State, counters and latched run configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PH_IDLE;
      scnt_q    <= SCNT_ZERO;
      dcnt_q    <= LEN_ZERO;
      ad_len_q  <= LEN_ZERO;
      msg_len_q <= LEN_ZERO;
      key_q     <= {KEY_BITS{1'b0}};
      iv_q      <= {KEY_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      dcnt_q    <= dcnt_d;
      ad_len_q  <= ad_len_d;
      msg_len_q <= msg_len_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
    end
  end

  assign bus.step_en   = step_en_s;
  assign bus.ca        = ca_s;
  assign bus.cb        = cb_s;
  assign bus.mbit      = mbit_s;
  assign bus.din_ready = din_ready_s;
  assign bus.ct_valid  = ct_valid_s;
  assign bus.tag_valid = tag_valid_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.phase     = state_q;

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// Scoreboard bench for acorn_phase_ctrl: expected per-step control words are queued at start, popped on step_en.
module tb_acorn_phase_ctrl;
  import acorn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  acorn_phase_ctrl_if #(.LEN_W(16)) bus ();
  acorn_phase_ctrl #(.LEN_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [2:0] ph_seq[$];
  logic [2:0] last_ph = 3'd0;
  bit mon_en = 1'b0;
  int step_cnt, tag_cnt;
  int ph_steps [0:7];
  logic stream [0:63];

  logic [2:0] m_ph;
  logic [7:0] m_exp;
  logic m_exp_se;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, bus.phase, bus.step_en, bus.ca, bus.cb, bus.mbit, bus.din_ready,
            bus.ct_valid, bus.tag_valid, bus.busy, bus.done};
  endfunction

  function automatic logic [7:0] pk(input logic [2:0] ph, input logic a, input logic b,
                                    input logic m, input logic ct, input logic tg);
    return {ph, a, b, m, ct, tg};
  endfunction

  // Expected step sequence of one complete run, derived from the phase definitions.
  task automatic push_exp(input logic [127:0] k, input logic [127:0] v, input int adl, input int ml);
    logic mb;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128) mb = k[i];
      else if (i < 256) mb = v[i-128];
      else if (i == 256) mb = ~k[0];
      else mb = k[i % 128];
      exp_q.push_back(pk(3'd1, 1'b1, 1'b1, mb, 1'b0, 1'b0));
    end
    for (int j = 0; j < adl; j++) exp_q.push_back(pk(3'd2, 1'b1, 1'b1, stream[j], 1'b0, 1'b0));
    for (int s = 0; s < 256; s++) exp_q.push_back(pk(3'd3, s < 128, 1'b1, s == 0, 1'b0, 1'b0));
    for (int j = 0; j < ml; j++) exp_q.push_back(pk(3'd4, 1'b1, 1'b0, stream[adl+j], 1'b1, 1'b0));
    for (int s = 0; s < 256; s++) exp_q.push_back(pk(3'd5, s < 128, 1'b0, s == 0, 1'b0, 1'b0));
    for (int s = 0; s < 768; s++) exp_q.push_back(pk(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, s >= 640));
  endtask

  // Per-cycle monitor: handshake/status consistency and scoreboard pop on every step.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ph = bus.phase;
      if (m_ph != last_ph) begin
        ph_seq.push_back(m_ph);
        last_ph = m_ph;
      end
      m_exp_se = (m_ph inside {3'd1, 3'd3, 3'd5, 3'd6}) | ((m_ph inside {3'd2, 3'd4}) & bus.din_valid);
      chk("ctrl", {28'd0, bus.step_en, bus.din_ready, bus.busy, bus.done},
          {28'd0, m_exp_se, (m_ph == 3'd2) || (m_ph == 3'd4), (m_ph != 3'd0) && (m_ph != 3'd7), m_ph == 3'd7});
      if (bus.step_en) begin
        step_cnt++;
        ph_steps[m_ph]++;
        if (bus.tag_valid) tag_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed step in phase %0d expected none", m_ph);
        end
        if (exp_q.size() != 0) begin
          m_exp = exp_q.pop_front();
          chk("step", {24'd0, m_ph, bus.ca, bus.cb, bus.mbit, bus.ct_valid, bus.tag_valid}, {24'd0, m_exp});
        end
      end else begin
        chk("idle_ctl", {27'd0, bus.ca, bus.cb, bus.mbit, bus.ct_valid, bus.tag_valid}, 32'd0);
      end
    end
  end

  task automatic run(input logic [127:0] k, input logic [127:0] v, input int adl, input int ml,
                     input bit toggle, input bit repulse, input int abort_at,
                     output int done_c, output int done_n);
    int c, kidx;
    bit stop, rep_enc, consumed;
    for (int i = 0; i < 64; i++) stream[i] = 1'($urandom);
    exp_q.delete();
    push_exp(k, v, adl, ml);
    step_cnt = 0;
    tag_cnt = 0;
    for (int i = 0; i < 8; i++) ph_steps[i] = 0;
    ph_seq.delete();
    last_ph = 3'd0;
    bus.key = k;
    bus.iv = v;
    bus.ad_len = 16'(adl);
    bus.msg_len = 16'(ml);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    c = 1; kidx = 0; done_c = 0; done_n = 0; stop = 1'b0; rep_enc = 1'b0;
    while (!stop) begin
      bus.din_valid = toggle ? ((c % 2) == 1) : 1'b1;
      bus.din = (kidx < 64) ? stream[kidx] : 1'b0;
      @(negedge clk);
      consumed = bus.din_ready & bus.din_valid;
      if (bus.done) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (repulse && !rep_enc && bus.phase == 3'd4) begin
        bus.start = 1'b1;
        bus.ad_len = 16'd999;
        bus.msg_len = 16'd77;
        bus.key = ~k;
        rep_enc = 1'b1;
      end else if (repulse && bus.phase == 3'd7) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", outs(), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_ph = 3'd0;
        mon_en = 1'b1;
        stop = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (consumed) kidx++;
        c++;
        if ((done_c != 0 && c > done_c + 3) || c > 6000) stop = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  int dc, dn;
  logic [2:0] ph_ref [0:5];

  initial begin
    bus.start = 1'b0;
    bus.key = 128'd0;
    bus.iv = 128'd0;
    bus.ad_len = 16'd0;
    bus.msg_len = 16'd0;
    bus.din_valid = 1'b0;
    bus.din = 1'b0;
    ph_ref[0] = 3'd1; ph_ref[1] = 3'd3; ph_ref[2] = 3'd5;
    ph_ref[3] = 3'd6; ph_ref[4] = 3'd7; ph_ref[5] = 3'd0;

    #2;
    chk("reset_outputs", outs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Zero-length run: timing, tag window, phase walk.
    run(128'd0, 128'd0, 0, 0, 1'b0, 1'b0, 0, dc, dn);
    chk("zero_done_cycle", 32'(dc), 32'd3073);
    chk("zero_done_pulses", 32'(dn), 32'd1);
    chk("zero_steps", 32'(step_cnt), 32'd3072);
    chk("zero_tag_cnt", 32'(tag_cnt), 32'd128);
    chk("zero_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("ph_seq_len", 32'(ph_seq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ph_seq.size()) chk("ph_seq", {29'd0, ph_seq[i]}, {29'd0, ph_ref[i]});
    end

    // INIT message-bit pattern.
    run(128'h1, {128{1'b1}}, 0, 0, 1'b0, 1'b0, 0, dc, dn);
    chk("init_done_cycle", 32'(dc), 32'd3073);
    chk("init_sb_drained", 32'(exp_q.size()), 32'd0);

    // AD/ENC with din_valid toggling every cycle.
    run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
        8, 4, 1'b1, 1'b0, 0, dc, dn);
    chk("tog_ad_steps", 32'(ph_steps[2]), 32'd8);
    chk("tog_enc_steps", 32'(ph_steps[4]), 32'd4);
    chk("tog_steps", 32'(step_cnt), 32'd3084);
    chk("tog_done_pulses", 32'(dn), 32'd1);
    chk("tog_sb_drained", 32'(exp_q.size()), 32'd0);

    // start re-pulsed in ENC and in DONE must be ignored.
    run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
        3, 5, 1'b0, 1'b1, 0, dc, dn);
    chk("rep_done_cycle", 32'(dc), 32'd3081);
    chk("rep_done_pulses", 32'(dn), 32'd1);
    chk("rep_ad_steps", 32'(ph_steps[2]), 32'd3);
    chk("rep_enc_steps", 32'(ph_steps[4]), 32'd5);
    chk("rep_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("rep_idle_after", outs(), 32'd0);

    // Reset at INIT step 500, then a full run from INIT step 0.
    run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
        0, 0, 1'b0, 1'b0, 500, dc, dn);
    chk("abort_steps_before", 32'(step_cnt), 32'd501);
    run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
        0, 0, 1'b0, 1'b0, 0, dc, dn);
    chk("post_abort_done_cycle", 32'(dc), 32'd3073);
    chk("post_abort_steps", 32'(step_cnt), 32'd3072);
    chk("post_abort_sb_drained", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
